wb_unit: RTL and testbench

Writeback stage directly upstream of the register file write port. Accepts one retiring instruction per handshake from the execute stage. For loads, it waits for the LSU read response, then aligns and sign/zero-extends the data. It drives a registered single-cycle register-file write (wen/waddr/wdata) and a retire pulse for difftest.

---
 rtl/wb_unit_pkg.sv | 16 +
 rtl/wb_unit_if.sv | 37 +++
 rtl/wb_unit_load_extend.sv | 36 +++
 rtl/wb_unit.sv | 89 ++++++++
 tb/tb_wb_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_unit_pkg.sv
// wb_unit shared types: load funct3 encodings
// and the writeback FSM state.
package wb_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      LOAD_WAIT
   } wb_state_t;

endpackage

// File: rtl/wb_unit_if.sv
// Execute-to-writeback handshake bundle.
// master = execute stage, slave = wb_unit.
interface wb_unit_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_pc;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_wen;
   logic [DATA_WIDTH-1:0] in_result;
   logic                  in_is_load;
   logic [2:0]            in_funct3;

   modport master (
      output in_valid,
      output in_pc,
      output in_rd,
      output in_wen,
      output in_result,
      output in_is_load,
      output in_funct3,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_pc,
      input  in_rd,
      input  in_wen,
      input  in_result,
      input  in_is_load,
      input  in_funct3,
      output in_ready
   );
endinterface

// File: rtl/wb_unit_load_extend.sv
// Load lane select and sign/zero extension
// for a naturally aligned 32-bit read word.
module load_extend
   import wb_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      half_sel = rdata[{addr[1], 4'b0000} +: 16];
      data     = rdata;
      // Reserved encodings fall through to a full word.
      unique case (1'b1)
         funct3 == F3_LB:
            data = {{24{byte_sel[7]}}, byte_sel};
         funct3 == F3_LBU:
            data = {24'h0, byte_sel};
         funct3 == F3_LH:
            data = {{16{half_sel[15]}}, half_sel};
         funct3 == F3_LHU:
            data = {16'h0, half_sel};
         funct3 == F3_LW:
            data = rdata;
         default:
            data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: registered RF write port and
// retire pulse; loads wait for the LSU response.
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wb_unit_if.slave              ex,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  retire_valid,
   output logic [DATA_WIDTH-1:0] retire_pc,
   output logic                  busy
);

   wb_state_t             state;
   logic [ADDR_WIDTH-1:0] ld_rd;
   logic                  ld_wen;
   logic [DATA_WIDTH-1:0] ld_pc;
   logic [2:0]            ld_funct3;
   logic [1:0]            ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;

   assign ex.in_ready = (state == IDLE);
   assign busy        = (state == LOAD_WAIT);

   load_extend u_ext (
      .funct3 (ld_funct3),
      .addr   (ld_addr),
      .rdata  (mem_rdata),
      .data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         rf_wen       <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         retire_valid <= 1'b0;
         retire_pc    <= '0;
         ld_rd        <= '0;
         ld_wen       <= 1'b0;
         ld_pc        <= '0;
         ld_funct3    <= '0;
         ld_addr      <= '0;
      end else begin
         rf_wen       <= 1'b0;
         retire_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ex.in_valid && ex.in_is_load) begin
                  ld_rd     <= ex.in_rd;
                  ld_wen    <= ex.in_wen;
                  ld_pc     <= ex.in_pc;
                  ld_funct3 <= ex.in_funct3;
                  ld_addr   <= ex.in_result[1:0];
                  state     <= LOAD_WAIT;
               end else if (ex.in_valid) begin
                  rf_wen       <= ex.in_wen
                                  && (ex.in_rd != '0);
                  rf_waddr     <= ex.in_rd;
                  rf_wdata     <= ex.in_result;
                  retire_valid <= 1'b1;
                  retire_pc    <= ex.in_pc;
               end
            end
            LOAD_WAIT: begin
               if (mem_rvalid) begin
                  rf_wen       <= ld_wen && (ld_rd != '0);
                  rf_waddr     <= ld_rd;
                  rf_wdata     <= ld_data;
                  retire_valid <= 1'b1;
                  retire_pc    <= ld_pc;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit.
// Inputs driven and outputs sampled 1ns after posedge.
module tb_wb_unit;
   import wb_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic        busy;

   int checks;
   int failures;

   wb_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) ex_if ();

   wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex           (ex_if),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .retire_valid (retire_valid),
      .retire_pc    (retire_pc),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h want 0x%08h",
                  tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".rf_wen"}, 32'(rf_wen), 0);
      chk({tag, ".retire"}, 32'(retire_valid), 0);
   endtask

   task automatic put_alu(input logic [4:0]  rd,
                          input logic [31:0] res,
                          input logic [31:0] pc);
      ex_if.in_valid   = 1'b1;
      ex_if.in_is_load = 1'b0;
      ex_if.in_wen     = 1'b1;
      ex_if.in_rd      = rd;
      ex_if.in_result  = res;
      ex_if.in_pc      = pc;
      ex_if.in_funct3  = 3'b000;
   endtask

   task automatic do_load(input string       tag,
                          input logic [2:0]  f3,
                          input logic [1:0]  addr,
                          input logic [4:0]  rd,
                          input logic [31:0] rdata,
                          input logic [31:0] exp);
      ex_if.in_valid   = 1'b1;
      ex_if.in_is_load = 1'b1;
      ex_if.in_wen     = 1'b1;
      ex_if.in_rd      = rd;
      ex_if.in_result  = {30'h0000_0400, addr};
      ex_if.in_pc      = 32'h0000_0800;
      ex_if.in_funct3  = f3;
      tick;
      // Scramble fields: the DUT must use latched copies.
      ex_if.in_valid   = 1'b0;
      ex_if.in_rd      = 5'd31;
      ex_if.in_result  = 32'hFFFF_FFFF;
      ex_if.in_funct3  = ~f3;
      ex_if.in_pc      = 32'h0;
      chk({tag, ".busy"}, 32'(busy), 1);
      idle_chk({tag, ".wait"});
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk({tag, ".rf_wen"}, 32'(rf_wen),
          32'(rd != 5'd0));
      chk({tag, ".waddr"}, 32'(rf_waddr), 32'(rd));
      chk({tag, ".wdata"}, rf_wdata, exp);
      chk({tag, ".retire"}, 32'(retire_valid), 1);
      chk({tag, ".pc"}, retire_pc, 32'h0000_0800);
      chk({tag, ".ready"}, 32'(ex_if.in_ready), 1);
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      clk              = 1'b0;
      rst_n            = 1'b0;
      mem_rvalid       = 1'b0;
      mem_rdata        = 32'h0;
      put_alu(5'd5, 32'h1234_5678, 32'h0000_0040);

      // Reset with a valid offer pending
      for (int i = 0; i < 2; i++) begin
         tick;
         idle_chk("rst");
         chk("rst.waddr", 32'(rf_waddr), 0);
         chk("rst.wdata", rf_wdata, 0);
         chk("rst.pc", retire_pc, 0);
         chk("rst.busy", 32'(busy), 0);
      end
      ex_if.in_valid = 1'b0;
      rst_n = 1'b1;
      tick;
      idle_chk("rst.rel");
      chk("rst.ready", 32'(ex_if.in_ready), 1);

      // Back-to-back ALU retires
      for (int i = 1; i <= 3; i++) begin
         put_alu(5'(i), 32'h11 * i, 32'h100 + 4 * i);
         tick;
         chk("alu.rf_wen", 32'(rf_wen), 1);
         chk("alu.waddr", 32'(rf_waddr), i);
         chk("alu.wdata", rf_wdata, 32'h11 * i);
         chk("alu.retire", 32'(retire_valid), 1);
         chk("alu.pc", retire_pc, 32'h100 + 4 * i);
      end
      ex_if.in_valid = 1'b0;
      tick;
      idle_chk("alu.gap");

      // Write to x0 retires without a write
      put_alu(5'd0, 32'hDEAD_BEEF, 32'h0000_0200);
      tick;
      ex_if.in_valid = 1'b0;
      chk("x0.rf_wen", 32'(rf_wen), 0);
      chk("x0.retire", 32'(retire_valid), 1);
      chk("x0.pc", retire_pc, 32'h0000_0200);
      tick;
      idle_chk("x0.gap");

      // Load extraction on 0x80FF7F01
      do_load("lb2", F3_LB, 2'd2, 5'd7,
              32'h80FF_7F01, 32'hFFFF_FFFF);
      do_load("lb1", F3_LB, 2'd1, 5'd7,
              32'h80FF_7F01, 32'h0000_007F);
      do_load("lbu3", F3_LBU, 2'd3, 5'd7,
              32'h80FF_7F01, 32'h0000_0080);
      do_load("lh0", F3_LH, 2'd0, 5'd7,
              32'h80FF_7F01, 32'h0000_7F01);
      do_load("lh2", F3_LH, 2'd2, 5'd7,
              32'h80FF_7F01, 32'hFFFF_80FF);
      do_load("lhu3", F3_LHU, 2'd3, 5'd7,
              32'h80FF_7F01, 32'h0000_80FF);
      do_load("lw", F3_LW, 2'd3, 5'd7,
              32'h80FF_7F01, 32'h80FF_7F01);
      do_load("f3_7", 3'b111, 2'd1, 5'd7,
              32'h80FF_7F01, 32'h80FF_7F01);
      do_load("ldx0", F3_LW, 2'd0, 5'd0,
              32'h1234_5678, 32'h1234_5678);

      // Load latency 4 with a stalled ALU op behind it
      ex_if.in_valid   = 1'b1;
      ex_if.in_is_load = 1'b1;
      ex_if.in_wen     = 1'b1;
      ex_if.in_rd      = 5'd4;
      ex_if.in_result  = 32'h0000_1000;
      ex_if.in_pc      = 32'h0000_0300;
      ex_if.in_funct3  = F3_LW;
      tick;
      put_alu(5'd9, 32'h99, 32'h0000_0304);
      for (int i = 0; i < 4; i++) begin
         chk("lat.busy", 32'(busy), 1);
         chk("lat.ready", 32'(ex_if.in_ready), 0);
         idle_chk("lat.wait");
         if (i < 3) tick;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      tick;
      mem_rvalid = 1'b0;
      chk("lat.rf_wen", 32'(rf_wen), 1);
      chk("lat.waddr", 32'(rf_waddr), 4);
      chk("lat.wdata", rf_wdata, 32'hCAFE_F00D);
      chk("lat.pc", retire_pc, 32'h0000_0300);
      chk("lat.ready", 32'(ex_if.in_ready), 1);
      chk("lat.busy0", 32'(busy), 0);
      tick;
      ex_if.in_valid = 1'b0;
      chk("stall.rf_wen", 32'(rf_wen), 1);
      chk("stall.waddr", 32'(rf_waddr), 9);
      chk("stall.wdata", rf_wdata, 32'h99);
      chk("stall.pc", retire_pc, 32'h0000_0304);
      tick;
      idle_chk("stall.gap");

      // Reset mid-load, then a stray response
      ex_if.in_valid   = 1'b1;
      ex_if.in_is_load = 1'b1;
      ex_if.in_rd      = 5'd6;
      ex_if.in_pc      = 32'h0000_0400;
      tick;
      ex_if.in_valid = 1'b0;
      chk("mid.busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mid.busy0", 32'(busy), 0);
      chk("mid.ready", 32'(ex_if.in_ready), 1);
      idle_chk("mid.rst");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      tick;
      mem_rvalid = 1'b0;
      idle_chk("stray");
      chk("stray.busy", 32'(busy), 0);
      tick;
      idle_chk("stray2");
      chk("stray2.ready", 32'(ex_if.in_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
